dmem_responder: RTL

- Responder end of the MEM-stage data-memory interface: takes the MEM stage's read/write strobes, address and store data, and answers after a fixed, parameterised access latency.
- Holds the word-addressed data array.
- Raises a stall toward the pipeline hazard logic until the response is ready, so slow memory can replace the single-cycle data memory without changing the MEM stage.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage; optional misaligned-access trap via DMEM_MISALIGN_TRAP_EN.
// Latency: response LATENCY cycles after acceptance; stall covers acceptance cycle through LATENCY-1.
// Backpressure: one request in flight, req_ready only in IDLE, stall freezes the pipeline meanwhile.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] mem_out,
  output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        resp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic             wr;
    logic             mis;
    logic [IDX_W-1:0] idx;
    logic [31:0]      dat;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req_in, req_q, cur;
  logic        req_vld, accept, commit;
  logic [31:0] mem [DEPTH_WORDS];

  // Upper address bits fold away (addresses wrap); byte offset only matters for the trap.
  logic unused_addr;
  assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};

  assign req_vld    = mem_read | mem_write;
  assign req_in.wr  = mem_write;
  assign req_in.idx = address[IDX_W+1:2];
  assign req_in.dat = write_data;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_in.mis = (address[1:0] != 2'b00);
`else
  assign req_in.mis = 1'b0;
`endif

  // With LATENCY=1 the commit happens straight out of IDLE, before the latch is loaded.
  assign cur = (state == IDLE) ? req_in : req_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_vld) begin
          stall   = 1'b1;
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = RESP;
            commit    = 1'b1;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      mem_out <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_q <= req_in;
      end
      if (commit && !cur.wr) begin
        mem_out <= cur.mis ? 32'h0 : mem[cur.idx];
      end
    end
  end

  // Array is never cleared; rst_n gate drops a commit that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur.wr && !cur.mis) begin
      mem[cur.idx] <= cur.dat;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= cur.mis;
    end
  end

  assign resp_err = resp_valid & err_q;
`endif

endmodule
